// File: rtl/apb_bus_arbiter.sv
// Round-robin arbiter sharing one downstream APB master between NB_REQ upstream requesters.
// The granted transfer is replayed downstream and its ACCESS phase is bounded by a PREADY timeout.
module apb_bus_arbiter #(
  parameter int NB_REQ         = 2,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NB_REQ-1:0]                req_psel_i,
  input  logic [NB_REQ-1:0]                req_penable_i,
  input  logic [NB_REQ-1:0]                req_pwrite_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0] req_paddr_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0] req_pwdata_i,
  output logic [NB_REQ*APB_DATA_WIDTH-1:0] req_prdata_o,
  output logic [NB_REQ-1:0]                req_pready_o,
  output logic [NB_REQ-1:0]                req_pslverr_o,
  output logic                             m_psel_o,
  output logic                             m_penable_o,
  output logic                             m_pwrite_o,
  output logic [APB_ADDR_WIDTH-1:0]        m_paddr_o,
  output logic [APB_DATA_WIDTH-1:0]        m_pwdata_o,
  input  logic [APB_DATA_WIDTH-1:0]        m_prdata_i,
  input  logic                             m_pready_i,
  input  logic                             m_pslverr_i,
  output logic [NB_REQ-1:0]                grant_o,
  output logic                             timeout_o
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int CW    = (CNT_WIDTH > 0) ? CNT_WIDTH : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

  // IDLE: arbitrate | SETUP: PSEL only | ACCESS: PENABLE, wait PREADY | RESP: pready to owner
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NB_REQ-1:0]      grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                   m_psel_q, m_psel_d;
  logic                   m_penable_q, m_penable_d;
  logic                   m_pwrite_q, m_pwrite_d;
  logic [AW-1:0]          m_paddr_q, m_paddr_d;
  logic [DW-1:0]          m_pwdata_q, m_pwdata_d;
  logic [NB_REQ*DW-1:0]   req_prdata_q, req_prdata_d;
  logic [NB_REQ-1:0]      req_pready_q, req_pready_d;
  logic [NB_REQ-1:0]      req_pslverr_q, req_pslverr_d;
  logic                   timeout_q, timeout_d;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W-1:0]       cand;

  assign cnt_inc = cnt_q + 1'b1;

  // First requesting index at or above the RR pointer, wrapping modulo NB_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NB_REQ; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NB_REQ);
      if (!win_found && req_psel_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    gnt_idx_d     = gnt_idx_q;
    grant_d       = grant_q;
    cnt_d         = cnt_q;
    m_psel_d      = m_psel_q;
    m_penable_d   = m_penable_q;
    m_pwrite_d    = m_pwrite_q;
    m_paddr_d     = m_paddr_q;
    m_pwdata_d    = m_pwdata_q;
    req_prdata_d  = '0;
    req_pready_d  = '0;
    req_pslverr_d = '0;
    timeout_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gnt_idx_d          = win_idx;
          grant_d            = '0;
          grant_d[win_idx]   = 1'b1;
          m_pwrite_d         = req_pwrite_i[win_idx];
          m_paddr_d          = req_paddr_i[win_idx*AW +: AW];
          m_pwdata_d         = req_pwdata_i[win_idx*DW +: DW];
          m_psel_d           = 1'b1;
          state_d            = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_penable_d = 1'b1;
        state_d     = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (m_pready_i) begin
          for (int i = 0; i < NB_REQ; i++) begin
            if (grant_q[i]) begin
              req_pready_d[i]          = 1'b1;
              req_pslverr_d[i]         = m_pslverr_i;
              req_prdata_d[i*DW +: DW] = m_prdata_i;
            end
          end
          m_psel_d    = 1'b0;
          m_penable_d = 1'b0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (TO_EN && (cnt_inc == TO_VAL)) begin
            // Abort: owner sees an error response with zero data.
            req_pready_d  = grant_q;
            req_pslverr_d = grant_q;
            timeout_d     = 1'b1;
            m_psel_d      = 1'b0;
            m_penable_d   = 1'b0;
            state_d       = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        rr_d    = (gnt_idx_q == IDX_W'(NB_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
        cnt_d   = '0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      rr_q          <= '0;
      gnt_idx_q     <= '0;
      grant_q       <= '0;
      cnt_q         <= '0;
      m_psel_q      <= 1'b0;
      m_penable_q   <= 1'b0;
      m_pwrite_q    <= 1'b0;
      m_paddr_q     <= '0;
      m_pwdata_q    <= '0;
      req_prdata_q  <= '0;
      req_pready_q  <= '0;
      req_pslverr_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      gnt_idx_q     <= gnt_idx_d;
      grant_q       <= grant_d;
      cnt_q         <= cnt_d;
      m_psel_q      <= m_psel_d;
      m_penable_q   <= m_penable_d;
      m_pwrite_q    <= m_pwrite_d;
      m_paddr_q     <= m_paddr_d;
      m_pwdata_q    <= m_pwdata_d;
      req_prdata_q  <= req_prdata_d;
      req_pready_q  <= req_pready_d;
      req_pslverr_q <= req_pslverr_d;
      timeout_q     <= timeout_d;
    end
  end

  assign req_prdata_o  = req_prdata_q;
  assign req_pready_o  = req_pready_q;
  assign req_pslverr_o = req_pslverr_q;
  assign m_psel_o      = m_psel_q;
  assign m_penable_o   = m_penable_q;
  assign m_pwrite_o    = m_pwrite_q;
  assign m_paddr_o     = m_paddr_q;
  assign m_pwdata_o    = m_pwdata_q;
  assign grant_o       = grant_q;
  assign timeout_o     = timeout_q;

  // Upstream PENABLE carries no extra information: the replay uses its own phase sequencing.
  logic unused_penable;
  assign unused_penable = ^req_penable_i;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Directed bench for apb_bus_arbiter: table of single transfers plus contention and reset-in-ACCESS sequences.
module tb_apb_bus_arbiter;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [1:0]    req_psel = '0;
  logic [1:0]    req_penable = '0;
  logic [1:0]    req_pwrite = '0;
  logic [63:0]   req_paddr = '0;
  logic [63:0]   req_pwdata = '0;
  logic [63:0]   req_prdata_o;
  logic [1:0]    req_pready_o;
  logic [1:0]    req_pslverr_o;
  logic          m_psel_o, m_penable_o, m_pwrite_o;
  logic [31:0]   m_paddr_o, m_pwdata_o;
  logic [31:0]   slv_rdata = '0;
  logic          slv_err = 1'b0;
  logic          m_pready_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  int total = 0;
  int bad = 0;
  int slv_wait = 0;
  int acc_cnt = 0;

  always #5 clk_i = ~clk_i;

  apb_bus_arbiter #(
    .NB_REQ(2), .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_psel_i(req_psel), .req_penable_i(req_penable), .req_pwrite_i(req_pwrite),
    .req_paddr_i(req_paddr), .req_pwdata_i(req_pwdata),
    .req_prdata_o(req_prdata_o), .req_pready_o(req_pready_o), .req_pslverr_o(req_pslverr_o),
    .m_psel_o(m_psel_o), .m_penable_o(m_penable_o), .m_pwrite_o(m_pwrite_o),
    .m_paddr_o(m_paddr_o), .m_pwdata_o(m_pwdata_o),
    .m_prdata_i(slv_rdata), .m_pready_i(m_pready_i), .m_pslverr_i(slv_err),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  // Slave model: PREADY in ACCESS cycle slv_wait+1.
  always @(posedge clk_i) begin
    if (m_psel_o && m_penable_o) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign m_pready_i = m_psel_o && m_penable_o && (acc_cnt == slv_wait);

  typedef struct {
    int          req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_to;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req_psel = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_psel", 32'(m_psel_o), 32'd0);
    chk("rst_penable", 32'(m_penable_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_pready", 32'(req_pready_o), 32'd0);
    chk("rst_pslverr", 32'(req_pslverr_o), 32'd0);
    chk("rst_prdata_or", 32'(|req_prdata_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_paddr", m_paddr_o, 32'd0);
    rst_ni = 1'b1;
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    int cyc, first_sel, acc, to_cnt, np, pcyc, who, other;
    logic [31:0] prd, oth_prd;
    logic perr, oth_err, bus_ok, done;
    v = vecs[n];
    slv_wait = v.wait_n;
    slv_rdata = v.rdata;
    slv_err = v.err;
    req_pwrite[v.req] = v.wr;
    req_paddr[v.req*32 +: 32] = v.addr;
    req_pwdata[v.req*32 +: 32] = v.wdata;
    req_psel[v.req] = 1'b1;
    cyc = 0; first_sel = -1; acc = 0; to_cnt = 0; np = 0; pcyc = -1; who = -1;
    prd = '1; oth_prd = '1; perr = 1'bx; oth_err = 1'bx; bus_ok = 1'b1; done = 1'b0;
    while (!done && cyc < 60) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (m_psel_o) begin
        if (first_sel < 0) first_sel = cyc;
        if (m_paddr_o !== v.addr || m_pwrite_o !== v.wr || grant_o !== (2'b01 << v.req)) bus_ok = 1'b0;
        if (v.wr && m_pwdata_o !== v.wdata) bus_ok = 1'b0;
      end
      if (m_psel_o && m_penable_o) acc++;
      if (timeout_o) to_cnt++;
      if (|req_pready_o) begin
        np++;
        pcyc = cyc;
        who = req_pready_o[1] ? 1 : 0;
        other = 1 - who;
        prd = req_prdata_o[who*32 +: 32];
        perr = req_pslverr_o[who];
        oth_prd = req_prdata_o[other*32 +: 32];
        oth_err = req_pslverr_o[other];
        req_psel = '0;
        done = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
    if (|req_pready_o) np++;
    if (timeout_o) to_cnt++;
    chk($sformatf("v%0d_owner", n), 32'(who), 32'(v.req));
    chk($sformatf("v%0d_prdata", n), prd, v.exp_rdata);
    chk($sformatf("v%0d_pslverr", n), 32'(perr), 32'(v.exp_err));
    chk($sformatf("v%0d_other_prdata", n), oth_prd, 32'd0);
    chk($sformatf("v%0d_other_pslverr", n), 32'(oth_err), 32'd0);
    chk($sformatf("v%0d_timeouts", n), 32'(to_cnt), 32'(v.exp_to));
    chk($sformatf("v%0d_access_cycles", n), 32'(acc), 32'(v.exp_acc));
    chk($sformatf("v%0d_psel_cycle", n), 32'(first_sel), 32'd1);
    chk($sformatf("v%0d_pready_cycle", n), 32'(pcyc), 32'(v.exp_acc + 2));
    chk($sformatf("v%0d_pready_pulses", n), 32'(np), 32'd1);
    chk($sformatf("v%0d_bus_fields", n), 32'(bus_ok), 32'd1);
    chk($sformatf("v%0d_idle_psel", n), 32'(m_psel_o), 32'd0);
    chk($sformatf("v%0d_idle_grant", n), 32'(grant_o), 32'd0);
  endtask

  initial begin
    int cyc, nxf, cnt0, cnt1, both, np;
    int order[4];

    //          req wr   addr          wdata         wait rdata         err  exp_rdata     exp_err to acc
    vecs[0] = '{0, 1'b0, 32'h1A10_2000, 32'h0,        0,  32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1};
    vecs[1] = '{1, 1'b1, 32'h1A10_4008, 32'h55,       3,  32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 0, 4};
    vecs[2] = '{0, 1'b0, 32'h1A10_3004, 32'h0,        1,  32'hA5A5_0001, 1'b1, 32'hA5A5_0001, 1'b1, 0, 2};
    vecs[3] = '{1, 1'b0, 32'h1A10_500C, 32'h0,        255, 32'hFFFF_FFFF, 1'b0, 32'h0,        1'b1, 1, 8};
    vecs[4] = '{0, 1'b1, 32'h1A10_6010, 32'h0BAD_CAFE, 2,  32'h0000_0042, 1'b0, 32'h0000_0042, 1'b0, 0, 3};
    vecs[5] = '{1, 1'b0, 32'h1A10_7000, 32'h0,        0,  32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 1};

    @(posedge clk_i);
    #1;
    do_reset();

    // Contention from reset: both requesters hold PSEL for four transfers.
    slv_wait = 0; slv_rdata = 32'h0000_1111; slv_err = 1'b0;
    req_paddr = {32'h1A10_0104, 32'h1A10_0100};
    req_psel = 2'b11;
    for (int i = 0; i < 4; i++) order[i] = -1;
    cyc = 0; nxf = 0; cnt0 = 0; cnt1 = 0; both = 0;
    while (nxf < 4 && cyc < 60) begin
      @(posedge clk_i);
      #1;
      cyc++;
      if (req_pready_o == 2'b11) both++;
      else if (req_pready_o == 2'b01) begin order[nxf] = 0; nxf++; cnt0++; end
      else if (req_pready_o == 2'b10) begin order[nxf] = 1; nxf++; cnt1++; end
    end
    req_psel = '0;
    chk("rr_transfers", 32'(nxf), 32'd4);
    chk("rr_order0", 32'(order[0]), 32'd0);
    chk("rr_order1", 32'(order[1]), 32'd1);
    chk("rr_order2", 32'(order[2]), 32'd0);
    chk("rr_order3", 32'(order[3]), 32'd1);
    chk("rr_cnt0", 32'(cnt0), 32'd2);
    chk("rr_cnt1", 32'(cnt1), 32'd2);
    chk("rr_both", 32'(both), 32'd0);

    // Reset during an ACCESS wait state; the RR pointer must return to 0.
    do_reset();
    run_vec(0);
    slv_wait = 255;
    req_paddr[63:32] = 32'h1A10_0200;
    req_psel = 2'b10;
    cyc = 0;
    while (!m_penable_o && cyc < 20) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("rstacc_reached_access", 32'(m_penable_o), 32'd1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    req_psel = '0;
    @(posedge clk_i);
    #1;
    chk("rstacc_psel", 32'(m_psel_o), 32'd0);
    chk("rstacc_penable", 32'(m_penable_o), 32'd0);
    chk("rstacc_grant", 32'(grant_o), 32'd0);
    rst_ni = 1'b1;
    np = 0;
    for (int i = 0; i < 4; i++) begin
      if (|req_pready_o) np++;
      @(posedge clk_i);
      #1;
    end
    chk("rstacc_no_pready", 32'(np), 32'd0);
    slv_wait = 0;
    req_psel = 2'b11;
    cyc = 0;
    while (grant_o == 2'b00 && cyc < 10) begin
      @(posedge clk_i);
      #1;
      cyc++;
    end
    chk("rstacc_rr_ptr", 32'(grant_o), 32'd1);
    req_psel = '0;

    do_reset();
    for (int n = 0; n < 6; n++) run_vec(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
